modsq_result_collapse: RTL

Converts the redundant-form squaring result into a plain binary integer. The squarer wrapper emits NUM_ELEMENTS coefficients, each 17 bits wide in a 32-bit slot, plus a one-cycle valid pulse; this block sits on that output and propagates carries one coefficient per cycle. It presents a single nonredundant word to the host side over a valid/ready handshake.

---
 rtl/modsq_result_collapse.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/modsq_result_collapse.sv
// -----------------------------------------------------------------------------
// modsq_result_collapse
//
// Converts the redundant-form squaring result into a plain binary integer.
// All NUM_ELEMENTS coefficients are captured in one cycle. Carries are then
// propagated one coefficient per cycle. The finished word is offered to the
// host over a valid/ready handshake.
//
// Ports:
//   clk           in   single clock
//   reset         in   asynchronous, active-low reset
//   sq_valid      in   one-cycle pulse, sq_in holds a new squaring result
//   sq_in         in   NUM_ELEMENTS slots of 2*WORD_LEN bits; low COEFF_BITS used
//   result        out  collapsed integer (OUT_LEN bits)
//   result_valid  out  result is stable and offered
//   result_ready  in   consumer accepts the result
//   busy          out  carry pass in progress
//   drop_err      out  one-cycle pulse, an sq_valid could not be accepted
//   range_err     out  one-cycle pulse, a captured slot had nonzero upper bits
//
// Build option:
//   MODSQ_COLLAPSE_RANGE_CHECK_EN - when defined, flags nonzero bits above
//   COEFF_BITS in any slot at capture time. When undefined, range_err is tied
//   to 0. The result is identical either way.
// -----------------------------------------------------------------------------
module modsq_result_collapse #(
  parameter int MOD_LEN               = 1024,
  parameter int WORD_LEN              = 16,
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int NUM_ELEMENTS          = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
  parameter int COEFF_BITS            = 17,
  parameter int OUT_LEN               = NUM_ELEMENTS * WORD_LEN + 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                sq_valid,
  input  logic [NUM_ELEMENTS*2*WORD_LEN-1:0]  sq_in,
  output logic [OUT_LEN-1:0]                  result,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic                                busy,
  output logic                                drop_err,
  output logic                                range_err
);

  localparam int SLOT_W  = 2 * WORD_LEN;
  localparam int SUM_W   = COEFF_BITS + 1;      // coeff + carry, 18 bits by default
  localparam int CARRY_W = SUM_W - WORD_LEN;    // carry never exceeds 2, fits in 2 bits
  localparam int K_W     = $clog2(NUM_ELEMENTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CARRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [K_W-1:0]         k_reg;
  logic [CARRY_W-1:0]     carry_reg;
  logic [CARRY_W-1:0]     top_reg;
  logic                   result_valid_reg;
  logic                   busy_reg;
  logic                   drop_err_reg;

  logic [COEFF_BITS-1:0]  coeff_mem     [NUM_ELEMENTS];
  logic [COEFF_BITS-1:0]  capture_coeff [NUM_ELEMENTS];
  logic [WORD_LEN-1:0]    word_reg      [NUM_ELEMENTS];

  logic                   accept;
  logic                   last_step;
  logic [SUM_W-1:0]       sum_next;

  // A new input is taken in IDLE, or in DONE in the same cycle the consumer
  // takes the current result (back-to-back).
  assign accept    = sq_valid &&
                     ((state_reg == IDLE) || ((state_reg == DONE) && result_ready));
  assign last_step = (k_reg == K_W'(NUM_ELEMENTS - 1));
  assign sum_next  = SUM_W'(coeff_mem[k_reg]) + SUM_W'(carry_reg);

  generate
    for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_slot
      assign capture_coeff[gi] = sq_in[SLOT_W*gi +: COEFF_BITS];
      assign result[WORD_LEN*gi +: WORD_LEN] = word_reg[gi];
    end
  endgenerate

  assign result[OUT_LEN-1 -: CARRY_W] = top_reg;

  // Shadow copy of the coefficients; its contents are irrelevant until the
  // next capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        coeff_mem[i] <= capture_coeff[i];
      end
    end
  end

  // Result words: word k is written in the k-th cycle of the carry pass and
  // is held otherwise, so the previous result survives through IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        word_reg[i] <= '0;
      end
    end else if (state_reg == CARRY) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        if (k_reg == K_W'(i)) begin
          word_reg[i] <= sum_next[WORD_LEN-1:0];
        end
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      k_reg            <= '0;
      carry_reg        <= '0;
      top_reg          <= '0;
      result_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      drop_err_reg     <= 1'b0;
    end else begin
      drop_err_reg <= sq_valid && !accept;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= CARRY;
            k_reg     <= '0;
            carry_reg <= '0;
            busy_reg  <= 1'b1;
          end
        end
        CARRY: begin
          carry_reg <= sum_next[SUM_W-1:WORD_LEN];
          k_reg     <= k_reg + 1'b1;
          if (last_step) begin
            // The carry out of the top coefficient becomes the two MSBs.
            top_reg          <= sum_next[SUM_W-1:WORD_LEN];
            state_reg        <= DONE;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid_reg <= 1'b0;
            if (sq_valid) begin
              state_reg <= CARRY;
              k_reg     <= '0;
              carry_reg <= '0;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg        <= IDLE;
          busy_reg         <= 1'b0;
          result_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign result_valid = result_valid_reg;
  assign busy         = busy_reg;
  assign drop_err     = drop_err_reg;

`ifdef MODSQ_COLLAPSE_RANGE_CHECK_EN
  logic [NUM_ELEMENTS-1:0] slot_over;
  logic                    range_err_reg;

  generate
    for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_range
      assign slot_over[gi] = |sq_in[SLOT_W*gi+COEFF_BITS +: SLOT_W-COEFF_BITS];
    end
  endgenerate

  // Only inputs that are actually captured are checked; dropped ones are
  // already reported through drop_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      range_err_reg <= 1'b0;
    end else begin
      range_err_reg <= accept && (|slot_over);
    end
  end

  assign range_err = range_err_reg;
`else
  // The upper slot bits are intentionally ignored in this build.
  logic [NUM_ELEMENTS-1:0] unused_upper;

  generate
    for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_unused
      assign unused_upper[gi] = |sq_in[SLOT_W*gi+COEFF_BITS +: SLOT_W-COEFF_BITS];
    end
  endgenerate

  assign range_err = 1'b0;
`endif

endmodule
